gfx_pixel_write_arbiter: RTL and testbench

- Shares the single AXI-master pixel-write port (`addr_to_write` / `color_to_write` / `m00_axi_init_axi_txn` / `m00_axi_txn_done`) between up to NUM_REQ shape drawers (rectangle, circle, line).
- Each drawer presents one pixel at a time on a valid/ready handshake.
- The arbiter grants requesters round-robin and issues exactly one AXI write per accepted pixel.
- It waits for completion before granting again, and reports per-pixel errors and stalls.

---
 rtl/gfx_pixel_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_gfx_pixel_write_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gfx_pixel_write_arbiter.sv
// Round-robin arbiter sharing one AXI pixel-write port between NUM_REQ shape drawers.
// Optional WAIT watchdog enabled by defining GFX_ARB_TIMEOUT_EN.
module gfx_pixel_write_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [ADDR_W-1:0]          addr_to_write,
  output logic [DATA_W-1:0]          color_to_write,
  output logic                       m00_axi_init_axi_txn,
  input  logic                       m00_axi_txn_done,
  input  logic                       m00_axi_error,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_sticky,
  output logic                       timeout_sticky,
  input  logic                       err_clear,
  output logic [31:0]                pixel_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              init_q, busy_q;
  logic              win_found_s;
  logic [IDW-1:0]    win_idx_s;
  logic              hs_s;
`ifdef GFX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
`endif

  // Winner search: first valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      else                idx = idx;
      if (!win_found_s && req_valid[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDW'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Combinational one-hot ready, suppressed outside IDLE and during reset.
  always_comb begin
    req_ready = '0;
    hs_s      = (state_q == S_IDLE) && win_found_s && !reset;
    if (hs_s) req_ready[win_idx_s] = 1'b1;
    else      req_ready = '0;
  end

  // Next-state logic for the IDLE/ISSUE/WAIT sequence and sticky flags.
  always_comb begin
    logic err_set, to_set;
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    color_d = color_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    to_set  = 1'b0;
`ifdef GFX_ARB_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          state_d = S_ISSUE;
          grant_d = win_idx_s;
          addr_d  = req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
          color_d = req_data[int'(win_idx_s)*DATA_W +: DATA_W];
          rr_d    = (int'(win_idx_s) == NUM_REQ - 1) ? '0 : win_idx_s + IDW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef GFX_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (m00_axi_txn_done) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 32'd1;
          err_set = m00_axi_error;
        end else begin
`ifdef GFX_ARB_TIMEOUT_EN
          // Done in the expiry cycle wins above; only a silent last cycle times out.
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            to_set  = 1'b1;
          end else begin
            wd_d    = wd_q + WD_W'(1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_set)        err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
    else                err_d = err_q;
`ifdef GFX_ARB_TIMEOUT_EN
    if (to_set)         to_d = 1'b1;
    else if (err_clear) to_d = 1'b0;
    else                to_d = to_q;
`else
    to_set = to_set;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      color_q <= '0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef GFX_ARB_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      init_q  <= (state_d == S_ISSUE);
      busy_q  <= (state_d != S_IDLE);
`ifdef GFX_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign addr_to_write        = addr_q;
  assign color_to_write       = color_q;
  assign grant_id             = grant_q;
  assign m00_axi_init_axi_txn = init_q;
  assign busy                 = busy_q;
  assign err_sticky           = err_q;
  assign pixel_count          = cnt_q;
`ifdef GFX_ARB_TIMEOUT_EN
  assign timeout_sticky       = to_q;
`else
  assign timeout_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_gfx_pixel_write_arbiter.sv
// Directed scoreboard bench for gfx_pixel_write_arbiter (3 requesters, 32-bit addr/data).
module tb_gfx_pixel_write_arbiter;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [95:0] req_addr, req_data;
  logic [31:0] addr_to_write, color_to_write;
  logic        init_txn, txn_done, axi_err;
  logic [1:0]  grant_id;
  logic        busy, err_sticky, timeout_sticky, err_clear;
  logic [31:0] pixel_count;

  gfx_pixel_write_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_aclk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .addr_to_write(addr_to_write),
    .color_to_write(color_to_write), .m00_axi_init_axi_txn(init_txn),
    .m00_axi_txn_done(txn_done), .m00_axi_error(axi_err), .grant_id(grant_id),
    .busy(busy), .err_sticky(err_sticky), .timeout_sticky(timeout_sticky),
    .err_clear(err_clear), .pixel_count(pixel_count)
  );

  typedef struct packed { logic [1:0] g; logic [31:0] a; logic [31:0] d; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int rr_m = 0, cnt_m = 0;
  bit err_m = 1'b0;
  logic [31:0] addr_tab [3] = '{32'h2000_0000, 32'h1000_0040, 32'h3000_0100};
  logic [31:0] data_tab [3] = '{32'h0000_00AA, 32'h00FF_0000, 32'h0000_FF00};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [2:0] m);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (rr_m + k) % 3;
      if (m[i]) return i;
    end
    return 0;
  endfunction

  // Called shortly after a negedge with the DUT in IDLE; delay=0 returns in the first WAIT cycle.
  task automatic do_pixel(input logic [2:0] mask, input int delay, input bit err,
                          input bit clr, input bit keep);
    int g;
    exp_t e;
    logic [2:0] oh;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*32 +: 32] = addr_tab[i];
      req_data[i*32 +: 32] = data_tab[i];
    end
    req_valid = mask;
    g = winner(mask);
    e.g = 2'(g); e.a = addr_tab[g]; e.d = data_tab[g];
    sb.push_back(e);
    oh = 3'b001 << g;
    #1;
    chk("ready_onehot", {61'd0, req_ready}, {61'd0, oh});
    chk("init_idle", {63'd0, init_txn}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("init_pulse", {63'd0, init_txn}, 64'd1);
    chk("busy_issue", {63'd0, busy}, 64'd1);
    chk("ready_issue", {61'd0, req_ready}, 64'd0);
    e = sb.pop_front();
    chk("grant_id", {62'd0, grant_id}, {62'd0, e.g});
    chk("addr", {32'd0, addr_to_write}, {32'd0, e.a});
    chk("color", {32'd0, color_to_write}, {32'd0, e.d});
    rr_m = (g + 1) % 3;
    if (!keep) req_valid = 3'b000;
    @(negedge clk);
    chk("init_one_cycle", {63'd0, init_txn}, 64'd0);
    chk("busy_wait", {63'd0, busy}, 64'd1);
    if (delay == 0) return;
    for (int k = 1; k < delay; k++) begin
      @(negedge clk);
      chk("ready_wait", {61'd0, req_ready}, 64'd0);
    end
    txn_done = 1'b1; axi_err = err; err_clear = clr;
    @(negedge clk);
    txn_done = 1'b0; axi_err = 1'b0; err_clear = 1'b0;
    cnt_m++;
    if (err) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    #1;
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("pixel_count", {32'd0, pixel_count}, 64'(cnt_m));
    chk("err_sticky", {63'd0, err_sticky}, {63'd0, err_m});
  endtask

  initial begin
    reset = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0;
    txn_done = 1'b0; axi_err = 1'b0; err_clear = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", {61'd0, req_ready}, 64'd0);
      chk("rst_init", {63'd0, init_txn}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end
    chk("rst_addr", {32'd0, addr_to_write}, 64'd0);
    chk("rst_color", {32'd0, color_to_write}, 64'd0);
    chk("rst_grant", {62'd0, grant_id}, 64'd0);
    chk("rst_err", {63'd0, err_sticky}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_sticky}, 64'd0);
    chk("rst_count", {32'd0, pixel_count}, 64'd0);
    reset = 1'b0;

    do_pixel(3'b111, 1, 1'b0, 1'b0, 1'b0);     // first grant is requester 0
    do_pixel(3'b010, 5, 1'b0, 1'b0, 1'b0);     // single pixel from requester 1
    do_pixel(3'b100, 2, 1'b0, 1'b0, 1'b0);     // brings rr pointer back to 0
    for (int p = 0; p < 6; p++) do_pixel(3'b111, 1, 1'b0, 1'b0, (p != 5));

    // txn_done/error in IDLE must be ignored
    txn_done = 1'b1; axi_err = 1'b1;
    @(negedge clk);
    txn_done = 1'b0; axi_err = 1'b0;
    #1;
    chk("idle_done_count", {32'd0, pixel_count}, 64'(cnt_m));
    chk("idle_done_err", {63'd0, err_sticky}, 64'd0);
    chk("idle_done_busy", {63'd0, busy}, 64'd0);

    do_pixel(3'b010, 1, 1'b0, 1'b0, 1'b0);
    do_pixel(3'b001, 3, 1'b1, 1'b0, 1'b0);
    do_pixel(3'b100, 1, 1'b1, 1'b1, 1'b0);     // set wins over clear
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0; err_m = 1'b0;
    #1;
    chk("err_cleared", {63'd0, err_sticky}, 64'd0);

`ifdef GFX_ARB_TIMEOUT_EN
    do_pixel(3'b001, 0, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    chk("wd_last_wait_busy", {63'd0, busy}, 64'd1);
    chk("wd_last_wait_to", {63'd0, timeout_sticky}, 64'd0);
    @(negedge clk);
    #1;
    chk("wd_expired_busy", {63'd0, busy}, 64'd0);
    chk("wd_expired_to", {63'd0, timeout_sticky}, 64'd1);
    chk("wd_expired_count", {32'd0, pixel_count}, 64'(cnt_m));
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    chk("to_cleared", {63'd0, timeout_sticky}, 64'd0);
    do_pixel(3'b001, 16, 1'b0, 1'b0, 1'b0);
    chk("done_at_expiry_to", {63'd0, timeout_sticky}, 64'd0);
`else
    do_pixel(3'b001, 0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("long_wait_busy", {63'd0, busy}, 64'd1);
    chk("long_wait_to", {63'd0, timeout_sticky}, 64'd0);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0; cnt_m++;
    #1;
    chk("long_wait_done_busy", {63'd0, busy}, 64'd0);
    chk("long_wait_done_count", {32'd0, pixel_count}, 64'(cnt_m));
`endif

    // Reset in WAIT, then a stale completion
    do_pixel(3'b010, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rr_m = 0; cnt_m = 0; err_m = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_count", {32'd0, pixel_count}, 64'd0);
    chk("midrst_addr", {32'd0, addr_to_write}, 64'd0);
    chk("midrst_grant", {62'd0, grant_id}, 64'd0);
    txn_done = 1'b1; axi_err = 1'b1;
    @(negedge clk);
    txn_done = 1'b0; axi_err = 1'b0;
    #1;
    chk("stale_done_count", {32'd0, pixel_count}, 64'd0);
    chk("stale_done_err", {63'd0, err_sticky}, 64'd0);
    chk("stale_done_busy", {63'd0, busy}, 64'd0);
    do_pixel(3'b011, 1, 1'b0, 1'b0, 1'b0);     // rr pointer restarted at 0

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
